// File: rtl/lcd_line_packer_if.sv
// Pixel-bus capture and framebuffer write port of lcd_line_packer.
// master = LCD source / framebuffer sink side, slave = the packer itself.
interface lcd_line_packer_if;
  logic        lcdClk;
  logic        lcdHsync;
  logic        lcdVsync;
  logic [11:0] lcdData;
  logic        fbWrEn;
  logic [13:0] fbWrAddr;
  logic [35:0] fbWrData;
  logic        frameDone;

  modport master (
    output lcdClk, lcdHsync, lcdVsync, lcdData,
    input  fbWrEn, fbWrAddr, fbWrData, frameDone
  );

  modport slave (
    input  lcdClk, lcdHsync, lcdVsync, lcdData,
    output fbWrEn, fbWrAddr, fbWrData, frameDone
  );
endinterface

// File: rtl/lcd_line_packer.sv
// Packs three RGB444 segments of each LCD line into 36-bit framebuffer words.
// Optional macro LCD_TESTPATTERN_EN replaces lcdData with a generated pattern.
module lcd_line_packer #(
  parameter int COLLEN     = 75,
  parameter int LINEPIXELS = 224,
  parameter int LINES      = 144,
  parameter int SYNCSTAGES = 2
) (
  input  logic                pxlClk,
  input  logic                rst,
  lcd_line_packer_if.slave    bus_io
);

  // Assumes 2*COLLEN < LINEPIXELS < 3*COLLEN, so every line ends with a flush.
  localparam int PW       = $clog2(LINEPIXELS + 1);
  localparam int LW       = $clog2(LINES + 1);
  localparam int KW       = $clog2(COLLEN);
  localparam int SW       = $clog2(2 * COLLEN);
  localparam int FLUSH_K0 = LINEPIXELS - 2 * COLLEN;

  typedef enum logic [1:0] {IDLE, WAITLINE, ACTIVE, FLUSH} state_t;

  logic [SYNCSTAGES-1:0] clk_sync_q, hs_sync_q, vs_sync_q;
  logic                  clk_prev_q, hs_prev_q, vs_prev_q;
  logic                  px_stb, hs_rise, vs_rise;

  state_t          state_q;
  logic [PW-1:0]   pix_q;
  logic [LW-1:0]   line_q;
  logic [13:0]     base_q;
  logic [KW-1:0]   flush_k_q;
  logic [11:0]     store_q [2*COLLEN];
  logic            wr_en_q, done_q, done_pend_q;
  logic [13:0]     wr_addr_q;
  logic [35:0]     wr_data_q;

  logic [11:0]     px_val;
  logic [KW-1:0]   k_act, k_sel;
  logic [SW-1:0]   idx0, idx1, idx_wr;
  logic [13:0]     addr_d;
  logic [11:0]     seg0, seg1;

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      clk_sync_q <= '0;
      hs_sync_q  <= '0;
      vs_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
    end else begin
      clk_sync_q[0] <= bus_io.lcdClk;
      hs_sync_q[0]  <= bus_io.lcdHsync;
      vs_sync_q[0]  <= bus_io.lcdVsync;
      for (int i = 1; i < SYNCSTAGES; i++) begin
        clk_sync_q[i] <= clk_sync_q[i-1];
        hs_sync_q[i]  <= hs_sync_q[i-1];
        vs_sync_q[i]  <= vs_sync_q[i-1];
      end
      clk_prev_q <= clk_sync_q[SYNCSTAGES-1];
      hs_prev_q  <= hs_sync_q[SYNCSTAGES-1];
      vs_prev_q  <= vs_sync_q[SYNCSTAGES-1];
    end
  end

  assign px_stb  = clk_sync_q[SYNCSTAGES-1] & ~clk_prev_q;
  assign hs_rise = hs_sync_q[SYNCSTAGES-1]  & ~hs_prev_q;
  assign vs_rise = vs_sync_q[SYNCSTAGES-1]  & ~vs_prev_q;

`ifdef LCD_TESTPATTERN_EN
  logic [7:0] p8, l8;
  assign p8     = 8'(pix_q);
  assign l8     = 8'(line_q);
  assign px_val = {p8[7:4], l8[7:4], p8[3:0] ^ l8[3:0]};
`else
  // Data rides the same flop depth as lcdClk so px_stb lines up with its pixel.
  logic [SYNCSTAGES-1:0][11:0] dat_sync_q;
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      dat_sync_q <= '0;
    end else begin
      dat_sync_q[0] <= bus_io.lcdData;
      for (int i = 1; i < SYNCSTAGES; i++) dat_sync_q[i] <= dat_sync_q[i-1];
    end
  end
  assign px_val = dat_sync_q[SYNCSTAGES-1];
`endif

  assign k_act  = KW'(pix_q - PW'(2 * COLLEN));
  assign k_sel  = (state_q == FLUSH) ? flush_k_q : k_act;
  assign idx0   = SW'(k_sel);
  assign idx1   = idx0 + SW'(COLLEN);
  assign idx_wr = SW'(pix_q);
  assign seg0   = store_q[idx0];
  assign seg1   = store_q[idx1];
  assign addr_d = base_q + 14'(k_sel);

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      line_q      <= '0;
      base_q      <= '0;
      flush_k_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
      for (int i = 0; i < 2 * COLLEN; i++) store_q[i] <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      done_q      <= done_pend_q;
      done_pend_q <= 1'b0;
      if (vs_rise) begin
        line_q  <= '0;
        pix_q   <= '0;
        base_q  <= '0;
        state_q <= WAITLINE;
      end else begin
        case (state_q)
          IDLE: ;
          WAITLINE: begin
            if (hs_rise) begin
              pix_q   <= '0;
              state_q <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (hs_rise) begin
              // Short line: abandon its tail, count it only if it carried pixels.
              pix_q <= '0;
              if (pix_q != '0) begin
                line_q <= line_q + LW'(1);
                base_q <= base_q + 14'(COLLEN);
                if (line_q == LW'(LINES - 1)) state_q <= IDLE;
              end
            end else if (px_stb) begin
              pix_q <= pix_q + PW'(1);
              if (pix_q < PW'(2 * COLLEN)) begin
                store_q[idx_wr] <= px_val;
              end else begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_d;
                wr_data_q <= {seg0, seg1, px_val};
              end
              if (pix_q == PW'(LINEPIXELS - 1)) begin
                flush_k_q <= KW'(FLUSH_K0);
                state_q   <= FLUSH;
              end
            end
          end
          FLUSH: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_d;
            wr_data_q <= {seg0, seg1, 12'd0};
            if (flush_k_q == KW'(COLLEN - 1)) begin
              line_q <= line_q + LW'(1);
              base_q <= base_q + 14'(COLLEN);
              if (line_q == LW'(LINES - 1)) begin
                done_pend_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                state_q <= WAITLINE;
              end
            end else begin
              flush_k_q <= flush_k_q + KW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus_io.fbWrEn    = wr_en_q;
  assign bus_io.fbWrAddr  = wr_addr_q;
  assign bus_io.fbWrData  = wr_data_q;
  assign bus_io.frameDone = done_q;

endmodule
